// File: rtl/riscv_crypto_aes_fwd_col.sv
// Byte-serial forward AES column: SubBytes through one shared S-box, optional MixColumns, AddRoundKey.
// Define AES_FWD_MIXCOL_EN to build in MixColumns; without it every operation is a final round.
module riscv_crypto_aes_fwd_col (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] col_i,
    input  logic [31:0] key_i,
    input  logic        mix_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic [1:0]  cnt;
    logic [31:0] col_q;
    logic [31:0] key_q;
    logic [31:0] sub_q;
    logic [7:0]  sbox_in;
    logic [7:0]  sbox_out;

    // Linear top layer: 21 linear terms of the input byte plus its LSB passed through.
    function automatic logic [21:0] sbox_top(input logic [7:0] x);
        logic u0, u1, u2, u3, u4, u5, u6, u7;
        logic t1, t2, t3, t4, t5, t6, t7, t8, t9, t10, t11, t12, t13, t14;
        logic t15, t16, t17, t18, t19, t20, t21, t22, t23, t24, t25, t26, t27;
        {u0, u1, u2, u3, u4, u5, u6, u7} = x;
        t1  = u0 ^ u3;
        t2  = u0 ^ u5;
        t3  = u0 ^ u6;
        t4  = u3 ^ u5;
        t5  = u4 ^ u6;
        t6  = t1 ^ t5;
        t7  = u1 ^ u2;
        t8  = u7 ^ t6;
        t9  = u7 ^ t7;
        t10 = t6 ^ t7;
        t11 = u1 ^ u5;
        t12 = u2 ^ u5;
        t13 = t3 ^ t4;
        t14 = t6 ^ t11;
        t15 = t5 ^ t11;
        t16 = t5 ^ t12;
        t17 = t9 ^ t16;
        t18 = u3 ^ u7;
        t19 = t7 ^ t18;
        t20 = t1 ^ t19;
        t21 = u6 ^ u7;
        t22 = t7 ^ t21;
        t23 = t2 ^ t22;
        t24 = t2 ^ t10;
        t25 = t20 ^ t17;
        t26 = t3 ^ t16;
        t27 = t1 ^ t12;
        return {t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15, t16, t17,
                t19, t20, t22, t23, t24, t25, t26, t27, u7};
    endfunction

    // Shared nonlinear middle layer: GF(2^4)-tower inversion core, 18 product terms out.
    function automatic logic [17:0] sbox_mid(input logic [21:0] y);
        logic t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15, t16, t17;
        logic t19, t20, t22, t23, t24, t25, t26, t27, d;
        logic m1, m2, m3, m4, m5, m6, m7, m8, m9, m10, m11, m12, m13, m14, m15;
        logic m16, m17, m18, m19, m20, m21, m22, m23, m24, m25, m26, m27, m28, m29, m30;
        logic m31, m32, m33, m34, m35, m36, m37, m38, m39, m40, m41, m42, m43, m44, m45;
        logic m46, m47, m48, m49, m50, m51, m52, m53, m54, m55, m56, m57, m58, m59, m60;
        logic m61, m62, m63;
        {t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15, t16, t17,
         t19, t20, t22, t23, t24, t25, t26, t27, d} = y;
        m1  = t13 & t6;
        m2  = t23 & t8;
        m3  = t14 ^ m1;
        m4  = t19 & d;
        m5  = m4 ^ m1;
        m6  = t3 & t16;
        m7  = t22 & t9;
        m8  = t26 ^ m6;
        m9  = t20 & t17;
        m10 = m9 ^ m6;
        m11 = t1 & t15;
        m12 = t4 & t27;
        m13 = m12 ^ m11;
        m14 = t2 & t10;
        m15 = m14 ^ m11;
        m16 = m3 ^ m2;
        m17 = m5 ^ t24;
        m18 = m8 ^ m7;
        m19 = m10 ^ m15;
        m20 = m16 ^ m13;
        m21 = m17 ^ m15;
        m22 = m18 ^ m13;
        m23 = m19 ^ t25;
        m24 = m22 ^ m23;
        m25 = m22 & m20;
        m26 = m21 ^ m25;
        m27 = m20 ^ m21;
        m28 = m23 ^ m25;
        m29 = m28 & m27;
        m30 = m26 & m24;
        m31 = m20 & m23;
        m32 = m27 & m31;
        m33 = m27 ^ m25;
        m34 = m21 & m22;
        m35 = m24 & m34;
        m36 = m24 ^ m25;
        m37 = m21 ^ m29;
        m38 = m32 ^ m33;
        m39 = m23 ^ m30;
        m40 = m35 ^ m36;
        m41 = m38 ^ m40;
        m42 = m37 ^ m39;
        m43 = m37 ^ m38;
        m44 = m39 ^ m40;
        m45 = m42 ^ m41;
        m46 = m44 & t6;
        m47 = m40 & t8;
        m48 = m39 & d;
        m49 = m43 & t16;
        m50 = m38 & t9;
        m51 = m37 & t17;
        m52 = m42 & t15;
        m53 = m45 & t27;
        m54 = m41 & t10;
        m55 = m44 & t13;
        m56 = m40 & t23;
        m57 = m39 & t19;
        m58 = m43 & t3;
        m59 = m38 & t22;
        m60 = m37 & t20;
        m61 = m42 & t1;
        m62 = m45 & t4;
        m63 = m41 & t2;
        return {m63, m62, m61, m60, m59, m58, m57, m56, m55,
                m54, m53, m52, m51, m50, m49, m48, m47, m46};
    endfunction

    // Forward bottom layer folds the output basis change and the affine map, including 0x63.
    function automatic logic [7:0] sbox_bot(input logic [17:0] m);
        logic m46, m47, m48, m49, m50, m51, m52, m53, m54;
        logic m55, m56, m57, m58, m59, m60, m61, m62, m63;
        logic l0, l1, l2, l3, l4, l5, l6, l7, l8, l9, l10, l11, l12, l13, l14;
        logic l15, l16, l17, l18, l19, l20, l21, l22, l23, l24, l25, l26, l27, l28, l29;
        {m63, m62, m61, m60, m59, m58, m57, m56, m55,
         m54, m53, m52, m51, m50, m49, m48, m47, m46} = m;
        l0  = m61 ^ m62;
        l1  = m50 ^ m56;
        l2  = m46 ^ m48;
        l3  = m47 ^ m55;
        l4  = m54 ^ m58;
        l5  = m49 ^ m61;
        l6  = m62 ^ l5;
        l7  = m46 ^ l3;
        l8  = m51 ^ m59;
        l9  = m52 ^ m53;
        l10 = m53 ^ l4;
        l11 = m60 ^ l2;
        l12 = m48 ^ m51;
        l13 = m50 ^ l0;
        l14 = m52 ^ m61;
        l15 = m55 ^ l1;
        l16 = m56 ^ l0;
        l17 = m57 ^ l1;
        l18 = m58 ^ l8;
        l19 = m63 ^ l4;
        l20 = l0 ^ l1;
        l21 = l1 ^ l7;
        l22 = l3 ^ l12;
        l23 = l18 ^ l2;
        l24 = l15 ^ l9;
        l25 = l6 ^ l10;
        l26 = l7 ^ l9;
        l27 = l8 ^ l10;
        l28 = l11 ^ l14;
        l29 = l11 ^ l17;
        return {l6 ^ l24, ~(l16 ^ l26), ~(l19 ^ l28), l6 ^ l21,
                l20 ^ l22, l25 ^ l29, ~(l13 ^ l27), ~(l6 ^ l23)};
    endfunction

    assign sbox_in  = col_q[{cnt, 3'b000} +: 8];
    assign sbox_out = sbox_bot(sbox_mid(sbox_top(sbox_in)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    accept     = 1'b1;
                    state_next = SUB;
                end
            end
            SUB: begin
                if (cnt == 2'd3) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One byte per SUB cycle; all four sub_q bytes are rewritten before OUT, so accept need not clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= 32'h0;
            key_q <= 32'h0;
            sub_q <= 32'h0;
            cnt   <= 2'd0;
        end else begin
            if (accept) begin
                col_q <= col_i;
                key_q <= key_i;
                cnt   <= 2'd0;
            end
            if (state == SUB) begin
                sub_q[{cnt, 3'b000} +: 8] <= sbox_out;
                cnt                       <= cnt + 2'd1;
            end
        end
    end

`ifdef AES_FWD_MIXCOL_EN
    logic        mix_q;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] mixed;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            mix_q <= 1'b0;
        end else if (accept) begin
            mix_q <= mix_i;
        end
    end

    assign b0 = sub_q[7:0];
    assign b1 = sub_q[15:8];
    assign b2 = sub_q[23:16];
    assign b3 = sub_q[31:24];

    always_comb begin
        mixed[7:0]   = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
        mixed[15:8]  = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
        mixed[23:16] = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
        mixed[31:24] = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
        result_o     = (mix_q ? mixed : sub_q) ^ key_q;
    end
`else
    logic mix_unused;

    assign mix_unused = mix_i;
    assign result_o   = sub_q ^ key_q;
`endif

endmodule
